demux4_buf: RTL

Registered 1-to-4 stream demultiplexer: the distributing counterpart of the datapath's 4-input selector. A single valid/ready input stream carries a 2-bit destination select. Each accepted word is steered into a one-entry holding register for that destination, and each destination drains through its own valid/ready handshake. The block sits between a single producer (e.g. a decode or issue stage) and up to four independent consumers that may stall separately.

---
 rtl/demux4_buf.sv | 115 +++++++++++
 1 files changed

// File: rtl/demux4_buf.sv
// demux4_buf: registered 1-to-4 valid/ready stream demultiplexer.
// Each accepted word is steered by in_select into a one-entry holding
// register for that destination; every destination drains independently.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready input stream handshake (in_ready is combinational)
//   in_select         destination index 0..3
//   in_data           payload
//   out_valid[3:0]    per-destination word held
//   out_ready[3:0]    per-destination consumer accept
//   out_data0..3      per-destination payload
//   count0..3         delivered-word counters (saturating)
//
// Optional feature: define DEMUX4_BUF_COUNT_EN to build the delivered-word
// counters; otherwise count0..count3 are tied to zero.
module demux4_buf #(
    parameter int unsigned width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_select,
    input  logic [width-1:0] in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [width-1:0] out_data0,
    output logic [width-1:0] out_data1,
    output logic [width-1:0] out_data2,
    output logic [width-1:0] out_data3,
    output logic [15:0]      count0,
    output logic [15:0]      count1,
    output logic [15:0]      count2,
    output logic [15:0]      count3
);

    localparam int unsigned num_out = 4;
    localparam int unsigned cnt_w   = 16;

    logic [num_out-1:0] full_q;
    logic [width-1:0]   data_q [num_out];
    logic [num_out-1:0] drain;
    logic [num_out-1:0] load;
    logic               accept;

    // Only the selected destination can stall the producer; a slot that is
    // draining this cycle can be refilled in the same cycle.
    assign in_ready = !full_q[in_select] | out_ready[in_select];
    assign accept   = in_valid & in_ready;
    assign drain    = full_q & out_ready;

    // One-hot load strobe for the destination receiving this cycle's word.
    always_comb begin
        load = '0;
        if (accept) begin
            load[in_select] = 1'b1;
        end
    end

    // Holding registers: a load wins over a drain so streaming keeps full set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= '0;
            for (int i = 0; i < num_out; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_out; i++) begin
                if (load[i]) begin
                    full_q[i] <= 1'b1;
                    data_q[i] <= in_data;
                end else if (drain[i]) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = full_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];

`ifdef DEMUX4_BUF_COUNT_EN
    logic [cnt_w-1:0] cnt_q [num_out];

    // Saturating delivered-word counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < num_out; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < num_out; i++) begin
                if (drain[i] && (cnt_q[i] != {cnt_w{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + cnt_w'(1);
                end
            end
        end
    end

    assign count0 = cnt_q[0];
    assign count1 = cnt_q[1];
    assign count2 = cnt_q[2];
    assign count3 = cnt_q[3];
`else
    assign count0 = '0;
    assign count1 = '0;
    assign count2 = '0;
    assign count3 = '0;
`endif

endmodule
